clock_div_bank: RTL

Multi-channel programmable clock divider for the stepper-drive datapath. It is the successor to the fixed single-channel divider. It produces NUM_CH independent square-wave clock enables from the 100 MHz system clock, each with a run-time half-period, a per-channel enable, and glitch-free reload. It also emits a one-cycle tick on each rising output edge, so step sequencers can use it without edge detection.

---
 rtl/clock_div_pkg.sv | 24 ++
 rtl/clock_div_ch.sv | 101 ++++++++++
 rtl/clock_div_bank.sv | 46 ++++
 3 files changed

// File: rtl/clock_div_pkg.sv
// Shared constants, types and helpers for the clock_div_bank divider channels.
// half_for_hz() converts a target output frequency into a half-period count.
package clock_div_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned CNT_W_DEF = 26;
    localparam logic [CNT_W_DEF-1:0] DEFAULT_HALF_DEF = 26'd5000000;

    // Source selected for the active half-period on the next edge.
    typedef enum logic [1:0] {
        ActKeep,
        ActLoad,
        ActPend
    } act_sel_e;

    // Frequencies of zero or above CLK_HZ/2 saturate to the fastest setting.
    function automatic int unsigned half_for_hz(input int unsigned hz);
        if (hz == 0 || hz > CLK_HZ / 2) begin
            return 0;
        end
        return CLK_HZ / (2 * hz) - 1;
    endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: half-period counter, glitch-free reload and rising-edge tick.
// A reload requested mid-period is held in pend and applied only at terminal count.
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int unsigned      CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             tc;
    act_sel_e         act_sel;

    assign tc = en_i && (count_q == act_q);

    always_comb begin
        count_d      = count_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        act_sel      = ActKeep;

        if (sync_i) begin
            // Bank restart wins over TC and load; the load slice is dropped.
            count_d      = '0;
            clk_out_d    = 1'b0;
            pend_valid_d = 1'b0;
            if (pend_valid_q) begin
                act_sel = ActPend;
            end
        end else if (!en_i) begin
            count_d      = '0;
            clk_out_d    = 1'b0;
            pend_valid_d = 1'b0;
            if (load_i) begin
                act_sel = ActLoad;
            end
        end else if (tc) begin
            count_d      = '0;
            clk_out_d    = ~clk_out_q;
            tick_d       = ~clk_out_q;
            pend_valid_d = 1'b0;
            if (load_i) begin
                act_sel = ActLoad;
            end else if (pend_valid_q) begin
                act_sel = ActPend;
            end
        end else begin
            count_d = count_q + CNT_W'(1);
            if (load_i) begin
                pend_d       = half_i;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (act_sel)
            ActLoad: act_d = half_i;
            ActPend: act_d = pend_q;
            default: act_d = act_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q      <= '0;
            act_q        <= DEFAULT_HALF;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_div_bank.sv
// NUM_CH independent programmable clock dividers with per-channel enable and reload.
// Define CLKDIV_SYNC_EN to add the sync port that restarts every channel in phase.
module clock_div_bank
    import clock_div_pkg::*;
#(
    parameter int unsigned      NUM_CH       = 4,
    parameter int unsigned      CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] half_period,
    input  logic [NUM_CH-1:0]       load,
`ifdef CLKDIV_SYNC_EN
    input  logic                    sync,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    logic sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_ch (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .en_i     (en[i]),
            .load_i   (load[i]),
            .sync_i   (sync_w),
            .half_i   (half_period[i*CNT_W +: CNT_W]),
            .clk_out_o(clk_out[i]),
            .tick_o   (tick[i])
        );
    end

endmodule
